tone_detector: RTL and testbench

- Receive-side counterpart to the square-wave sound generator.
- Samples an incoming 1-bit audio square wave and measures its period in clock cycles.
- Declares lock after consecutive stable periods and classifies the tone as one of eight notes, C4..C5, at a 50 MHz clock.
- Detects silence by timeout.

---
 rtl/tone_detector.sv | 227 ++++++++++++++++++++++
 tb/tb_tone_detector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tone_detector.sv
// Receive-side tone detector: measures the period of a 1-bit square wave,
// locks on a stable tone, classifies it as one of eight notes C4..C5 and flags silence.
module tone_detector #(
  parameter int CNT_W      = 20,
  parameter int MIN_PERIOD = 1000,
  parameter int TIMEOUT    = 262143,
  parameter int TOL        = 1024,
  parameter int LOCK_CNT   = 4
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSOUND,
  output logic [CNT_W-1:0] oPERIOD,
  output logic             oVALID,
  output logic             oLOCK,
  output logic             oSILENT,
  output logic [2:0]       oNOTE,
  output logic             oNOTE_OK
);

  localparam int MW = $clog2(LOCK_CNT) + 1;

  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0]    LOCK_AT = MW'(LOCK_CNT - 1);

  localparam logic [CNT_W-1:0] TH_C4  = CNT_W'(32'd180689);
  localparam logic [CNT_W-1:0] TH_D4  = CNT_W'(32'd160975);
  localparam logic [CNT_W-1:0] TH_E4  = CNT_W'(32'd147428);
  localparam logic [CNT_W-1:0] TH_F4  = CNT_W'(32'd135361);
  localparam logic [CNT_W-1:0] TH_G4  = CNT_W'(32'd120593);
  localparam logic [CNT_W-1:0] TH_A4  = CNT_W'(32'd107437);
  localparam logic [CNT_W-1:0] TH_B4  = CNT_W'(32'd98398);
  localparam logic [CNT_W-1:0] RNG_LO = CNT_W'(32'd92690);
  localparam logic [CNT_W-1:0] RNG_HI = CNT_W'(32'd196846);

  typedef enum logic [1:0] {
    ST_SILENT  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    logic [2:0] n;
    if      (p >= TH_C4) n = 3'd0;
    else if (p >= TH_D4) n = 3'd1;
    else if (p >= TH_E4) n = 3'd2;
    else if (p >= TH_F4) n = 3'd3;
    else if (p >= TH_G4) n = 3'd4;
    else if (p >= TH_A4) n = 3'd5;
    else if (p >= TH_B4) n = 3'd6;
    else                 n = 3'd7;
    return n;
  endfunction

  function automatic logic in_range(input logic [CNT_W-1:0] p);
    return (p >= RNG_LO) && (p <= RNG_HI);
  endfunction

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q, edge_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             silent_q, silent_d;
  logic [2:0]       note_q, note_d;
  logic             range_q, range_d;
  logic             note_ok_q, note_ok_d;

  logic             accept_s, timeout_s, capture_s, match_s;
  logic [CNT_W:0]   cnt_ext_s, prev_ext_s, diff_s;
  logic [MW-1:0]    match_inc_s;

  // Input synchronizer and rising-edge detect register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= iSOUND;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  assign accept_s    = edge_q & ((state_q == ST_SILENT) | (cnt_q >= MIN_P));
  assign capture_s   = accept_s & (state_q != ST_SILENT);
  assign timeout_s   = (cnt_q == TMO);
  assign cnt_ext_s   = {1'b0, cnt_q};
  assign prev_ext_s  = {1'b0, prev_q};
  assign diff_s      = (cnt_ext_s >= prev_ext_s) ? (cnt_ext_s - prev_ext_s)
                                                 : (prev_ext_s - cnt_ext_s);
  assign match_s     = prev_valid_q & (diff_s <= TOL_W);
  assign match_inc_s = match_q + MW'(1);

  // Next-state, period capture, lock and classification logic
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    match_d      = match_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    lock_d       = lock_q;
    silent_d     = silent_q;
    note_d       = note_q;
    range_d      = range_q;

    if (accept_s) begin
      cnt_d = CNT_W'(1);
    end else if (timeout_s) begin
      cnt_d = TMO;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // An edge on the timeout cycle takes priority over declaring silence
    if (accept_s) begin
      case (state_q)
        ST_SILENT: begin
          state_d      = ST_ACQUIRE;
          match_d      = {MW{1'b0}};
          prev_valid_d = 1'b0;
          silent_d     = 1'b0;
        end
        ST_ACQUIRE: begin
          if (match_s) begin
            match_d = match_inc_s;
            if (match_inc_s == LOCK_AT) begin
              state_d = ST_LOCKED;
              lock_d  = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            match_d = {MW{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_ACQUIRE;
            match_d = {MW{1'b0}};
            lock_d  = 1'b0;
          end
        end
        default: begin
          state_d = ST_SILENT;
          lock_d  = 1'b0;
        end
      endcase

      if (capture_s) begin
        period_d     = cnt_q;
        valid_d      = 1'b1;
        prev_d       = cnt_q;
        prev_valid_d = 1'b1;
        range_d      = in_range(cnt_q);
        if (in_range(cnt_q)) begin
          note_d = classify(cnt_q);
        end else begin
          note_d = note_q;
        end
      end else begin
        period_d = period_q;
      end
    end else if (timeout_s) begin
      state_d      = ST_SILENT;
      silent_d     = 1'b1;
      lock_d       = 1'b0;
      match_d      = {MW{1'b0}};
      prev_valid_d = 1'b0;
    end else begin
      state_d = state_q;
    end

    note_ok_d = lock_d & range_d;
  end

  // State and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= ST_SILENT;
      cnt_q        <= {CNT_W{1'b0}};
      prev_q       <= {CNT_W{1'b0}};
      prev_valid_q <= 1'b0;
      match_q      <= {MW{1'b0}};
      period_q     <= {CNT_W{1'b0}};
      valid_q      <= 1'b0;
      lock_q       <= 1'b0;
      silent_q     <= 1'b1;
      note_q       <= 3'd0;
      range_q      <= 1'b0;
      note_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      match_q      <= match_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      lock_q       <= lock_d;
      silent_q     <= silent_d;
      note_q       <= note_d;
      range_q      <= range_d;
      note_ok_q    <= note_ok_d;
    end
  end

  assign oPERIOD  = period_q;
  assign oVALID   = valid_q;
  assign oLOCK    = lock_q;
  assign oSILENT  = silent_q;
  assign oNOTE    = note_q;
  assign oNOTE_OK = note_ok_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: lock on A4, glitch rejection, retune to C5,
// silence timeout, out-of-range tone and asynchronous reset.
module tb_tone_detector;

  localparam int CNT_W = 20;
  localparam int P_A4  = 113636;
  localparam int P_C5  = 95557;
  localparam int P_OUT = 50000;

  logic             clk;
  logic             rst_n;
  logic             sound;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             lock;
  logic             silent;
  logic [2:0]       note;
  logic             note_ok;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  int vsnap   = 0;

  tone_detector #(
    .CNT_W(CNT_W), .MIN_PERIOD(1000), .TIMEOUT(262143), .TOL(1024), .LOCK_CNT(4)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSOUND(sound),
    .oPERIOD(period), .oVALID(valid), .oLOCK(lock), .oSILENT(silent),
    .oNOTE(note), .oNOTE_OK(note_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid === 1'b1) vcnt = vcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rise-to-rise period; optional 200-cycle low dip shortly after the rise
  task automatic tone(input int p, input int glitch_at);
    sound = 1'b1;
    if (glitch_at > 0) begin
      repeat (glitch_at) @(negedge clk);
      sound = 1'b0;
      repeat (200) @(negedge clk);
      sound = 1'b1;
      repeat (p / 2 - glitch_at - 200) @(negedge clk);
    end else begin
      repeat (p / 2) @(negedge clk);
    end
    sound = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sound = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period",  32'(period),  32'd0);
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_silent",  32'(silent),  32'd1);
    chk("rst_lock",    32'(lock),    32'd0);
    chk("rst_note",    32'(note),    32'd0);
    chk("rst_note_ok", 32'(note_ok), 32'd0);
    rst_n = 1'b1;

    repeat (2000) @(negedge clk);
    chk("idle_silent", 32'(silent), 32'd1);
    chk("idle_lock",   32'(lock),   32'd0);
    chk("idle_vcnt",   32'(vcnt),   32'd0);

    // A4: first edge only wakes the detector
    tone(P_A4, 0);
    chk("a4_e1_silent", 32'(silent), 32'd0);
    chk("a4_e1_vcnt",   32'(vcnt),   32'd0);
    repeat (3) tone(P_A4, 0);
    chk("a4_e4_vcnt",    32'(vcnt),    32'd3);
    chk("a4_e4_period",  32'(period),  32'(P_A4));
    chk("a4_e4_lock",    32'(lock),    32'd0);
    chk("a4_e4_note",    32'(note),    32'd5);
    chk("a4_e4_note_ok", 32'(note_ok), 32'd0);
    tone(P_A4, 0);
    chk("a4_e5_lock",    32'(lock),    32'd1);
    chk("a4_e5_note",    32'(note),    32'd5);
    chk("a4_e5_note_ok", 32'(note_ok), 32'd1);
    tone(P_A4, 0);
    chk("a4_e6_vcnt",    32'(vcnt),    32'd5);

    // Glitch 300 cycles after a rise: its edge lands inside MIN_PERIOD
    vsnap = vcnt;
    tone(P_A4, 300);
    chk("glitch_vcnt",   32'(vcnt),   32'(vsnap + 1));
    chk("glitch_period", 32'(period), 32'(P_A4));
    chk("glitch_lock",   32'(lock),   32'd1);

    // Retune to C5: the first C5 rise still closes an A4 period
    tone(P_C5, 0);
    chk("c5_e1_period", 32'(period), 32'(P_A4));
    chk("c5_e1_lock",   32'(lock),   32'd1);
    tone(P_C5, 0);
    chk("c5_new_period",  32'(period),  32'(P_C5));
    chk("c5_new_lock",    32'(lock),    32'd0);
    chk("c5_new_note",    32'(note),    32'd7);
    chk("c5_new_note_ok", 32'(note_ok), 32'd0);
    repeat (2) tone(P_C5, 0);
    chk("c5_m2_lock", 32'(lock), 32'd0);
    repeat (2) tone(P_C5, 0);
    chk("c5_lock",    32'(lock),    32'd1);
    chk("c5_note",    32'(note),    32'd7);
    chk("c5_note_ok", 32'(note_ok), 32'd1);

    // Silence: ~95.5k cycles already elapsed since the last edge
    repeat (150000) @(negedge clk);
    chk("pre_tmo_silent", 32'(silent), 32'd0);
    chk("pre_tmo_lock",   32'(lock),   32'd1);
    repeat (20000) @(negedge clk);
    chk("tmo_silent",  32'(silent),  32'd1);
    chk("tmo_lock",    32'(lock),    32'd0);
    chk("tmo_note_ok", 32'(note_ok), 32'd0);

    // Out-of-range tone: locks, but note is not meaningful and holds C5
    vsnap = vcnt;
    tone(P_OUT, 0);
    chk("out_e1_vcnt",   32'(vcnt),   32'(vsnap));
    chk("out_e1_silent", 32'(silent), 32'd0);
    repeat (5) tone(P_OUT, 0);
    chk("out_vcnt",    32'(vcnt),    32'(vsnap + 5));
    chk("out_period",  32'(period),  32'(P_OUT));
    chk("out_lock",    32'(lock),    32'd1);
    chk("out_note_ok", 32'(note_ok), 32'd0);
    chk("out_note",    32'(note),    32'd7);

    // Asynchronous reset mid-period
    sound = 1'b1;
    repeat (1000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period",  32'(period),  32'd0);
    chk("arst_valid",   32'(valid),   32'd0);
    chk("arst_silent",  32'(silent),  32'd1);
    chk("arst_lock",    32'(lock),    32'd0);
    chk("arst_note",    32'(note),    32'd0);
    chk("arst_note_ok", 32'(note_ok), 32'd0);
    sound = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    vsnap = vcnt;
    tone(P_OUT, 0);
    chk("post_rst_vcnt",   32'(vcnt),   32'(vsnap));
    chk("post_rst_silent", 32'(silent), 32'd0);
    chk("post_rst_lock",   32'(lock),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
